dds_voice_engine: RTL

- Parametrised successor of the fixed 4-slot DDS sample path. Runs NUM_CH phase-accumulator voices, each with its own waveform, volume and linear-decay envelope.
- Owns an internal per-frame sequencer, so the external master count is no longer needed. A single sample_tick_in pulse starts one frame.
- Each frame mixes all voices with saturation and emits one signed sample to the DAC/PWM stage through a one-cycle valid pulse.
- Configured through the same 16-bit data/address/valid write bus as the rest of the tone generator.

---
 rtl/dds_voice_pkg.sv | 19 +
 rtl/dds_wave_shaper.sv | 22 ++
 rtl/dds_voice_engine.sv | 113 +++++++++++
 3 files changed

// File: rtl/dds_voice_pkg.sv
// dds_voice_pkg: shared field addresses, enums, LFSR constants and saturation helper
package dds_voice_pkg;
  localparam logic [2:0] FLD_INCR  = 3'd0;
  localparam logic [2:0] FLD_VOL   = 3'd1;
  localparam logic [2:0] FLD_WAVE  = 3'd2;
  localparam logic [2:0] FLD_DECAY = 3'd3;
  localparam logic [2:0] FLD_KEY   = 3'd4;
  localparam logic [2:0] FLD_CTRL  = 3'd7;
  typedef enum logic [1:0] {W_SQUARE, W_SAW, W_TRI, W_NOISE} wave_e;
  typedef enum logic [2:0] {S_IDLE, S_ACC, S_SHAPE, S_SCALE, S_OUT} state_e;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/dds_wave_shaper.sv
// dds_wave_shaper: phase to signed 16-bit sample for square/saw/triangle/noise
module dds_wave_shaper
  import dds_voice_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [15:0] phase,
  input  logic [1:0]  wave,
  input  logic        adv,
  output logic [15:0] sample
);
  logic [15:0] lfsr, tri_w;
  always_comb begin
    tri_w = phase[15] ? ~{phase[14:0], 1'b0} : {phase[14:0], 1'b0};
    sample = wave == W_SQUARE ? (phase[15] ? 16'h8001 : 16'h7FFF) :
             wave == W_SAW    ? phase ^ 16'h8000 :
             wave == W_TRI    ? tri_w ^ 16'h8000 : lfsr;
  end
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) lfsr <= LFSR_SEED;
    else if (adv && wave == W_NOISE) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/dds_voice_engine.sv
// dds_voice_engine: NUM_CH-voice DDS with envelopes, per-frame sequencer and saturating mixer
module dds_voice_engine
  import dds_voice_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              sample_tick_in,
  input  logic [15:0]       data_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              data_valid_in,
  output logic [OUT_W-1:0]  data_out,
  output logic              data_valid_out,
  output logic              busy_out,
  output logic              overrun_out
);
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int MIX_W = OUT_W + 4;
  state_e state, state_n;
  logic [CH_W-1:0] ch, wch;
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] incr [NUM_CH];
  logic [7:0] vol [NUM_CH];
  logic [7:0] decay [NUM_CH];
  logic [7:0] env [NUM_CH];
  logic [1:0] wave [NUM_CH];
  logic [NUM_CH-1:0] gate, clr_pend;
  logic signed [MIX_W-1:0] mix;
  logic signed [24:0] prod;
  logic [15:0] shp, samp;
  logic [2:0] fld;
  logic wr, last;
  assign fld  = addr_in[5:3];
  assign wch  = addr_in[CH_W-1:0];
  assign wr   = data_valid_in && int'(addr_in[2:0]) < NUM_CH;
  assign last = ch == CH_W'(NUM_CH - 1);
  assign prod = $signed(samp) * $signed({1'b0, env[ch]});
  dds_wave_shaper u_shaper (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .phase    (acc[ch][ACC_W-1 -: 16]),
    .wave     (wave[ch]),
    .adv      (state == S_SHAPE),
    .sample   (shp)
  );
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) state <= S_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == S_IDLE  ? (sample_tick_in ? S_ACC : S_IDLE) :
              state == S_ACC   ? S_SHAPE :
              state == S_SHAPE ? S_SCALE :
              state == S_SCALE ? (last ? S_OUT : S_ACC) : S_IDLE;
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      ch <= '0;
      mix <= '0;
      samp <= '0;
      data_out <= '0;
      data_valid_out <= 1'b0;
      busy_out <= 1'b0;
      overrun_out <= 1'b0;
      gate <= '0;
      clr_pend <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        incr[i] <= '0;
        vol[i] <= '0;
        decay[i] <= '0;
        env[i] <= '0;
        wave[i] <= '0;
      end
    end else begin
      data_valid_out <= state == S_OUT;
      if (state == S_IDLE && sample_tick_in) begin
        ch <= '0;
        mix <= '0;
        busy_out <= 1'b1;
      end
      if (data_valid_in && fld == FLD_CTRL && data_in[0]) overrun_out <= 1'b0;
      if (sample_tick_in && busy_out) overrun_out <= 1'b1;
      if (state == S_SHAPE) samp <= shp;
      if (state == S_SCALE) begin
        mix <= mix + MIX_W'(prod >>> 8);
        ch <= last ? ch : ch + 1'b1;
        env[ch] <= gate[ch] ? vol[ch] : env[ch] > decay[ch] ? env[ch] - decay[ch] : 8'd0;
      end
      if (state == S_OUT) begin
        data_out <= OUT_W'(saturate(32'(mix >>> (16 - OUT_W)), OUT_W));
        busy_out <= 1'b0;
      end
      clr_pend <= '0;
      for (int i = 0; i < NUM_CH; i++)
        if (clr_pend[i]) acc[i] <= '0;
      if (state == S_ACC) acc[ch] <= acc[ch] + incr[ch];
      if (wr) begin
        if (fld == FLD_INCR) incr[wch] <= ACC_W'(data_in);
        if (fld == FLD_VOL) vol[wch] <= data_in[7:0];
        if (fld == FLD_WAVE) wave[wch] <= data_in[1:0];
        if (fld == FLD_DECAY) decay[wch] <= data_in[7:0];
        if (fld == FLD_KEY && data_in[0]) begin
          env[wch] <= vol[wch];
          gate[wch] <= 1'b1;
          if (state == S_ACC && ch == wch) clr_pend[wch] <= 1'b1;
          else acc[wch] <= '0;
        end else if (fld == FLD_KEY && data_in[1]) gate[wch] <= 1'b0;
      end
    end
endmodule
